vco_adc_multich: RTL and testbench
==================================

VCO_ADC_MULTICH -- requirements
Module: vco_adc_multich

Interface
REQ-001 Parameter N_CH, default 2: number of VCO channels, legal range 1..8.
REQ-002 Parameter CNT_W, default 16: edge-counter width per channel, legal range 8..24.
REQ-003 Parameter WIN_W, default 16: window-length field width.
REQ-004 Parameter FIFO_DEPTH, default 4: result FIFO entries, power of two, minimum 2.
REQ-005 wb_clk_i  in  1  sole clock; all logic in this domain.
REQ-006 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-007 vco_i  in  N_CH  raw VCO phase outputs, asynchronous to wb_clk_i.
REQ-008 en_i  in  1  block enable; low aborts any window.
REQ-009 mode_i  in  1  0 = single-shot, 1 = continuous.
REQ-010 start_i  in  1  single-cycle pulse; starts one window in single-shot mode.
REQ-011 win_len_i  in  WIN_W  window length in wb_clk_i cycles; value 0 is treated as 1.
REQ-012 clr_i  in  1  clears the sticky overrun flag and flushes the FIFO.
REQ-013 dout_o  out  N_CH*CNT_W  FIFO head; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-014 sat_o  out  N_CH  per-channel saturation flags belonging to the FIFO head entry.
REQ-015 dout_valid_o  out  1  FIFO non-empty.
REQ-016 dout_ready_i  in  1  consumer accepts the head; pop occurs when valid and ready are both high.
REQ-017 busy_o  out  1  high while a window is counting.
REQ-018 overrun_o  out  1  sticky; a result was dropped because the FIFO was full.
REQ-019 level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-020 Each vco_i bit passes through a 2-flop synchroniser plus a history flop; a count event is synced & ~history; the input-to-count latency is 3 cycles.
REQ-021 States: IDLE, RUN. IDLE->RUN on start_i with en_i=1 and mode_i=0, or on en_i=1 with mode_i=1. RUN->IDLE at window end when mode_i=0, or at any cycle where en_i=0.
REQ-022 win_len_i is latched on entry to each window; changes during RUN take effect at the next window.
REQ-023 A window spans exactly L cycles (L = latched length); events in all L cycles, including the last, are counted.
REQ-024 At the window's last cycle, counts and sat flags are pushed to the FIFO, and the counters and flags clear for the next window.
REQ-025 In continuous mode, windows are back-to-back with no gap cycle.
REQ-026 Counters saturate at 2^CNT_W-1 and never wrap; the channel's sat flag is set for that window.
REQ-027 A push while the FIFO is full is dropped and overrun_o is set, unless a pop occurs in the same cycle; in that case the push is accepted.
REQ-028 The FIFO is first-word-fall-through; dout_valid_o rises the cycle after the push.
REQ-029 start_i during RUN, or while en_i=0, is ignored.
REQ-030 en_i falling during RUN discards the partial window: no push, counters cleared.
REQ-031 clr_i has priority over a simultaneous push and pop: the FIFO empties, overrun_o clears, and the push is discarded.
REQ-032 busy_o equals (state == RUN).

Reset
REQ-033 While wb_rst_i is high: state = IDLE; synchroniser, counters and FIFO pointers are zero; dout_o = 0; sat_o = 0; dout_valid_o = 0; busy_o = 0; overrun_o = 0; level_o = 0.
REQ-034 Reset asserted mid-window discards all results without any push.

Structure
REQ-035 Package vco_adc_pkg holds the state enum and default parameter constants.
REQ-036 The result FIFO is the sub-module vco_adc_res_fifo, parametrised by width and depth.

Verification
REQ-037 Single-shot: N_CH=2, win_len=100, ch0 toggling at clk/4 and ch1 at clk/10 -> one entry: ch0=25±1, ch1=10±1, sat=00.
REQ-038 Saturation: CNT_W=8, win_len=1000, ch0 at clk/2 -> ch0=255 and sat_o[0]=1.
REQ-039 Continuous: win_len=10, 6 windows, dout_ready_i=0 -> level_o=4, overrun_o=1 after the 5th window, then clr_i -> level_o=0 and overrun_o=0.
REQ-040 Abort: en_i dropped 5 cycles into a 50-cycle window -> no entry, busy_o=0 on the next cycle.
REQ-041 Full-plus-pop: FIFO full, dout_ready_i=1 in the push cycle -> level_o stays 4 and overrun_o stays 0.
REQ-042 Reset mid-window (wb_rst_i asserted asynchronously) -> all outputs 0 immediately; no entry after release.

Source files
------------

// File: rtl/vco_adc_pkg.sv
// Shared types and default sizing for the multichannel VCO-based ADC.
package vco_adc_pkg;

    typedef enum logic {StIdle, StRun} state_e;

    localparam int unsigned DefNCh       = 2;
    localparam int unsigned DefCntW      = 16;
    localparam int unsigned DefWinW      = 16;
    localparam int unsigned DefFifoDepth = 4;

endpackage

// File: rtl/vco_adc_res_fifo.sv
// First-word-fall-through result FIFO with sticky overrun and synchronous flush.
module vco_adc_res_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [AW:0]      level,
    output logic             overrun
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [AW:0]      count_q;
    logic             overrun_q;
    logic             full, pop, push_ok;

    assign valid   = (count_q != '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop     = valid & ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push & (~full | pop);
    assign data    = valid ? mem_q[rd_q] : '0;
    assign level   = count_q;
    assign overrun = overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else if (clr) begin
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (pop) rd_q <= rd_q + AW'(1);
            if (push_ok) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= wr_q + AW'(1);
            end
            if (push && !push_ok) overrun_q <= 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vco_adc_multich.sv
// Multichannel VCO ADC: counts synchronised VCO rising edges over a programmable
// window and queues per-channel counts plus saturation flags in a result FIFO.
module vco_adc_multich
    import vco_adc_pkg::*;
#(
    parameter int unsigned N_CH       = DefNCh,
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned WIN_W      = DefWinW,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [N_CH-1:0]               vco_i,
    input  logic                          en_i,
    input  logic                          mode_i,
    input  logic                          start_i,
    input  logic [WIN_W-1:0]              win_len_i,
    input  logic                          clr_i,
    output logic [N_CH*CNT_W-1:0]         dout_o,
    output logic [N_CH-1:0]               sat_o,
    output logic                          dout_valid_o,
    input  logic                          dout_ready_i,
    output logic                          busy_o,
    output logic                          overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int unsigned DW = N_CH*CNT_W + N_CH;
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e                  state_q;
    logic [N_CH-1:0]         sync1_q, sync2_q, hist_q, ev;
    logic [N_CH*CNT_W-1:0]   cnt_q, cnt_inc;
    logic [N_CH-1:0]         sat_now;
    logic [WIN_W-1:0]        win_last_q, win_cnt_q, len_m1;
    logic                    last, push;
    logic [DW-1:0]           fifo_data;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
        end else begin
            sync1_q <= vco_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign ev = sync2_q & ~hist_q;

    always_comb begin
        cnt_inc = cnt_q;
        sat_now = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ev[k] && (cnt_q[k*CNT_W +: CNT_W] != CntMax)) begin
                cnt_inc[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
            sat_now[k] = (cnt_inc[k*CNT_W +: CNT_W] == CntMax);
        end
    end

    // Zero length behaves as a single-cycle window.
    assign len_m1 = (win_len_i == '0) ? '0 : win_len_i - WIN_W'(1);
    assign last   = (win_cnt_q == win_last_q);
    assign push   = (state_q == StRun) && en_i && last;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            win_last_q <= '0;
            win_cnt_q  <= '0;
            cnt_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q     <= '0;
                    win_cnt_q <= '0;
                    if (en_i && (mode_i || start_i)) begin
                        state_q    <= StRun;
                        win_last_q <= len_m1;
                    end
                end
                StRun: begin
                    if (!en_i) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        win_cnt_q <= '0;
                    end else if (last) begin
                        cnt_q      <= '0;
                        win_cnt_q  <= '0;
                        win_last_q <= len_m1;
                        if (!mode_i) state_q <= StIdle;
                    end else begin
                        cnt_q     <= cnt_inc;
                        win_cnt_q <= win_cnt_q + WIN_W'(1);
                    end
                end
            endcase
        end
    end

    assign busy_o = (state_q == StRun);

    vco_adc_res_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .clr       (clr_i),
        .push      (push),
        .push_data ({sat_now, cnt_inc}),
        .ready     (dout_ready_i),
        .valid     (dout_valid_o),
        .data      (fifo_data),
        .level     (level_o),
        .overrun   (overrun_o)
    );

    assign dout_o = fifo_data[N_CH*CNT_W-1:0];
    assign sat_o  = fifo_data[DW-1 -: N_CH];

endmodule

// File: tb/tb_vco_adc_multich.sv
// Randomised self-checking bench for vco_adc_multich against a window/queue model.
module tb_vco_adc_multich;

    localparam int N_CH = 2;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int EW = N_CH*CNT_W + N_CH;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_CH-1:0]         vco;
    logic                    en, mode, start, clr, ready;
    logic [WIN_W-1:0]        win_len;
    logic [N_CH*CNT_W-1:0]   dout;
    logic [N_CH-1:0]         sat;
    logic                    dout_valid, busy, overrun;
    logic [$clog2(FIFO_DEPTH):0] level;

    int checks = 0;
    int failures = 0;
    int hp [N_CH];
    int tick = 0;
    bit model_on = 0;

    vco_adc_multich #(
        .N_CH       (N_CH),
        .CNT_W      (CNT_W),
        .WIN_W      (WIN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .vco_i        (vco),
        .en_i         (en),
        .mode_i       (mode),
        .start_i      (start),
        .win_len_i    (win_len),
        .clr_i        (clr),
        .dout_o       (dout),
        .sat_o        (sat),
        .dout_valid_o (dout_valid),
        .dout_ready_i (ready),
        .busy_o       (busy),
        .overrun_o    (overrun),
        .level_o      (level)
    );

    always #5 clk = ~clk;

    // Model: a window is a run of L counting cycles; results land in a bounded queue.
    bit              m_run;
    int              m_rem;
    int              m_cnt [N_CH];
    bit              m_ovr;
    logic [EW-1:0]   mq [$];
    logic [N_CH-1:0] v_d1, v_d2, v_d3;   // vco samples 1, 2 and 3 edges ago

    function automatic int eff_len(input logic [WIN_W-1:0] l);
        return (l == 0) ? 1 : int'(l);
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [N_CH-1:0] ev;
        logic [EW-1:0]   ent;
        bit              m_push, m_pop;
        if (rst) begin
            m_run = 0; m_rem = 0; m_ovr = 0;
            for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
            mq.delete();
            v_d1 = '0; v_d2 = '0; v_d3 = '0;
        end else begin
            // A rising edge on the pin is counted three edges later.
            ev = v_d2 & ~v_d3;
            m_pop = (mq.size() > 0) && ready;
            m_push = 0;
            ent = '0;
            if (!m_run) begin
                if (en && (mode || start)) begin
                    m_run = 1;
                    m_rem = eff_len(win_len);
                    for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
                end
            end else if (!en) begin
                m_run = 0;
                for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
            end else begin
                for (int c = 0; c < N_CH; c++) m_cnt[c] += int'(ev[c]);
                m_rem--;
                if (m_rem == 0) begin
                    for (int c = 0; c < N_CH; c++) begin
                        ent[c*CNT_W +: CNT_W] = CNT_W'((m_cnt[c] >= MAXC) ? MAXC : m_cnt[c]);
                        ent[N_CH*CNT_W + c] = (m_cnt[c] >= MAXC);
                        m_cnt[c] = 0;
                    end
                    m_push = 1;
                    if (!mode) m_run = 0;
                    else m_rem = eff_len(win_len);
                end
            end
            if (clr) begin
                mq.delete();
                m_ovr = 0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    if (mq.size() < FIFO_DEPTH) mq.push_back(ent);
                    else m_ovr = 1;
                end
            end
            v_d3 = v_d2; v_d2 = v_d1; v_d1 = vco;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clock: compare at the falling edge, then drive the next vco sample.
    task automatic cyc();
        logic [EW-1:0] head;
        @(negedge clk);
        if (model_on) begin
            head = (mq.size() > 0) ? mq[0] : '0;
            chk("valid", dout_valid, mq.size() > 0);
            chk("level", level, mq.size());
            chk("busy", busy, m_run);
            chk("overrun", overrun, m_ovr);
            chk("dout", dout, head[N_CH*CNT_W-1:0]);
            chk("sat", sat, head[EW-1 -: N_CH]);
        end
        for (int c = 0; c < N_CH; c++)
            vco[c] = (hp[c] == 0) ? 1'($urandom_range(0, 1)) : 1'((tick / hp[c]) % 2);
        tick++;
    endtask

    task automatic wait_valid(input int n, input string name);
        int k = 0;
        while (dout_valid !== 1'b1 && k < n) begin
            cyc();
            k++;
        end
        chk(name, dout_valid, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_sat"}, sat, 0);
        chk({tag, "_valid"}, dout_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_level"}, level, 0);
    endtask

    initial begin
        int k;
        rst = 1; vco = '0; en = 0; mode = 0; start = 0; clr = 0; ready = 0; win_len = '0;
        hp[0] = 0; hp[1] = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 0;
        model_on = 1;
        cyc();

        // Single-shot: ch0 period 4, ch1 period 10, 100-cycle window.
        hp[0] = 2; hp[1] = 5;
        repeat (8) cyc();
        en = 1; mode = 0; win_len = 100; start = 1;
        cyc();
        start = 0;
        wait_valid(200, "single_valid");
        chk_range("single_ch0", int'(dout[CNT_W-1:0]), 24, 26);
        chk_range("single_ch1", int'(dout[2*CNT_W-1:CNT_W]), 9, 11);
        chk("single_sat", sat, 2'b00);
        chk("single_level", level, 1);
        ready = 1; cyc(); ready = 0;

        // Saturation: ch0 toggles every cycle for 1000 cycles.
        hp[0] = 1;
        win_len = 1000; start = 1;
        cyc();
        start = 0;
        wait_valid(1200, "sat_valid");
        chk("sat_ch0", dout[CNT_W-1:0], 255);
        chk("sat_flags", sat, 2'b01);
        ready = 1; cyc(); ready = 0;

        // Continuous 10-cycle windows with no consumer.
        hp[0] = 2;
        win_len = 10; mode = 1;
        repeat (42) cyc();
        chk("cont_level4", level, 4);
        chk("cont_no_ovr", overrun, 0);
        repeat (20) cyc();
        chk("cont_level_full", level, 4);
        chk("cont_overrun", overrun, 1);
        clr = 1; cyc(); clr = 0;
        chk("clr_level", level, 0);
        chk("clr_overrun", overrun, 0);
        en = 0; cyc();
        mode = 0; en = 1;

        // Abort 5 cycles into a 50-cycle window.
        win_len = 50; start = 1;
        cyc();
        start = 0;
        repeat (5) cyc();
        en = 0;
        cyc();
        chk("abort_busy", busy, 0);
        en = 1;
        repeat (60) cyc();
        chk("abort_level", level, 0);
        chk("abort_valid", dout_valid, 0);

        // Full FIFO, pop coinciding with the push.
        win_len = 10; mode = 1; ready = 0;
        k = 0;
        while (level !== 4 && k < 80) begin cyc(); k++; end
        chk("fpp_fill", level, 4);
        k = 0;
        while (!(m_run && m_rem == 1) && k < 20) begin cyc(); k++; end
        ready = 1; cyc(); ready = 0;
        chk("fpp_level", level, 4);
        chk("fpp_overrun", overrun, 0);
        en = 0; cyc();
        clr = 1; cyc(); clr = 0;
        en = 1; mode = 0;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0)
                for (int c = 0; c < N_CH; c++) hp[c] = $urandom_range(0, 6);
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            win_len = WIN_W'($urandom_range(0, 12));
            ready = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 199) == 0);
            cyc();
        end
        start = 0; clr = 0; ready = 0; en = 1; mode = 0;
        cyc();

        // Asynchronous reset in the middle of a window.
        win_len = 50; start = 1;
        cyc();
        start = 0;
        repeat (10) cyc();
        #2 rst = 1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 0;
        repeat (60) cyc();
        chk("post_rst_level", level, 0);
        chk("post_rst_valid", dout_valid, 0);
        chk("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
